clock_modulator_bank: RTL and testbench
=======================================

CLOCK_MODULATOR_BANK -- requirements
Module: clock_modulator_bank

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter NUM_CH, default 2, number of independent divider channels (1..16).
REQ-003 Parameter DIV_W, default 32, width of the per-channel half-period register and counter.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  global enable; low freezes every channel.
REQ-007 ch_en  input  NUM_CH  per-channel enable.
REQ-008 mode  input  NUM_CH  per-channel output mode: 0 = square wave, 1 = single-cycle pulse.
REQ-009 load  input  1  one-cycle strobe that writes load_div into channel load_ch.
REQ-010 load_ch  input  clog2(NUM_CH) (min 1)  target channel of load; out-of-range index ignored.
REQ-011 load_div  input  DIV_W  new half-period in clk cycles.
REQ-012 out  output  NUM_CH  per-channel modulated output, registered.
REQ-013 tick  output  NUM_CH  per-channel one-cycle wrap strobe, registered.

Function
REQ-014 Each channel SHALL hold div (DIV_W) and cnt (DIV_W); effective half-period = max(div,1).
REQ-015 Channel active when en & ch_en[i]; active: cnt increments by 1 per cycle.
REQ-016 Wrap: when active and cnt == eff_div-1, cnt SHALL return to 0 on the next edge and tick[i] SHALL be 1 for exactly that following cycle.
REQ-017 Square mode: out[i] SHALL toggle on every wrap; period = 2*eff_div cycles, 50% duty.
REQ-018 Pulse mode: out[i] SHALL equal tick[i] (high one cycle per eff_div cycles).
REQ-019 Mode change on a channel SHALL take effect at the next wrap; square-mode toggle state is retained across mode changes.
REQ-020 Inactive channel: cnt and square state held, tick[i] = 0, out[i] holds in square mode, 0 in pulse mode.
REQ-021 load to channel i SHALL write div, clear cnt to 0 on the same edge; square state unchanged; first wrap after load occurs eff_div active cycles later.
REQ-022 load and wrap on the same channel in the same cycle: load wins, no tick, no toggle.
REQ-023 load while channel inactive SHALL still update div and clear cnt.
REQ-024 div = 0 SHALL behave as div = 1 (wrap every active cycle; square out = clk/2).
REQ-025 Latency: tick/out registered, one cycle after the terminal count cycle; no combinational path from inputs to outputs.

Reset
REQ-026 On rst_n low (asynchronous): cnt = 0, out = 0, tick = 0, square state = 0, div = CLK_HZ/2 (0.5 s half-period) for every channel.
REQ-027 Reset deassertion mid-count SHALL restart counting from 0 on the first active edge; no spurious tick.

Configuration
REQ-028 Macro CLKMOD_SYNC_CLR_EN; when defined, adds input sync_clr (1 bit) that, when high, clears cnt, tick, out and square state of all channels on the next edge (div retained); sync_clr has priority over load and wrap.
REQ-029 Without CLKMOD_SYNC_CLR_EN the port does not exist and channels align only via reset or per-channel load.

Structure
REQ-030 Package clkmod_pkg SHALL hold HALF_SEC_DIV(clk_hz) = clk_hz/2 constant function, mode encoding constants (MODE_SQUARE = 0, MODE_PULSE = 1) and default DIV_W.
REQ-031 One sub-module clkmod_channel (counter, div register, square state, outputs) SHALL be instantiated NUM_CH times by a generate loop; the top holds only load decode and enable gating.

Verification (CLK_HZ = 8, NUM_CH = 2, DIV_W = 8)
REQ-032 Reset release, en = 1, ch_en = 2'b11, mode = 0 -> out[0] toggles every 4 cycles, tick[0] high one cycle per 4, first tick 4 cycles after first active edge.
REQ-033 load ch1 div = 3, mode[1] = 1 -> out[1] = tick[1] pulse every 3 cycles; ch0 unaffected.
REQ-034 load ch0 in cycle cnt == 3 (wrap cycle) -> no tick, no toggle, next tick eff_div cycles later.
REQ-035 load div = 0 on ch0 -> out[0] toggles every cycle, tick[0] continuously high.
REQ-036 en low for 5 cycles mid-count -> cnt, out frozen, tick 0; resume continues same count.
REQ-037 With CLKMOD_SYNC_CLR_EN, sync_clr pulse with channels at different phases -> both cnt = 0, out = 0 next cycle, subsequent ticks aligned per div.

Source files
------------

// File: rtl/clkmod_pkg.sv
// Shared constants and helpers for the clock modulator bank.
package clkmod_pkg;

  localparam int DEFAULT_DIV_W = 32;

  // Per-channel output mode encoding
  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Half-period count that gives a 0.5 s half-period (1 Hz square wave)
  function automatic int HALF_SEC_DIV(input int clk_hz);
    return clk_hz / 2;
  endfunction

endpackage

// File: rtl/clkmod_channel.sv
// One divider channel: half-period register, wrap counter, square toggle
// state and registered out/tick. Mode is latched on each wrap so a mode
// change only becomes visible at the next wrap.
module clkmod_channel
  import clkmod_pkg::*;
#(
  parameter int               DIV_W   = DEFAULT_DIV_W,
  parameter logic [DIV_W-1:0] RST_DIV = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active_i,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_div_i,
  input  logic             sync_clr_i,
  output logic             out_o,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] term_cnt;
  logic             sq_q, sq_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             out_q, out_d;
  logic             wrap;

  // A zero divider behaves like one: wrap on every active cycle
  assign eff_div  = (div_q == '0) ? DIV_W'(1) : div_q;
  assign term_cnt = eff_div - DIV_W'(1);
  assign wrap     = active_i && (cnt_q == term_cnt);

  // Next-state: clear beats load, load beats wrap, wrap beats plain count
  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    sq_d   = sq_q;
    mode_d = mode_q;
    tick_d = 1'b0;
    if (sync_clr_i) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (load_i) begin
      div_d = load_div_i;
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      mode_d = mode_i;
      // Toggle state only advances while in square mode, so it is
      // preserved across a detour through pulse mode
      if (mode_i == MODE_SQUARE) sq_d = ~sq_q;
    end else if (active_i) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    out_d = (mode_d == MODE_PULSE) ? tick_d : sq_d;
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= RST_DIV;
      cnt_q  <= '0;
      sq_q   <= 1'b0;
      mode_q <= MODE_SQUARE;
      tick_q <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      sq_q   <= sq_d;
      mode_q <= mode_d;
      tick_q <= tick_d;
      out_q  <= out_d;
    end
  end

  assign out_o  = out_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clock_modulator_bank.sv
// Bank of NUM_CH independent clock dividers producing square or pulse
// outputs plus a wrap tick per channel. The top only decodes the load
// strobe and gates the enables; all state lives in clkmod_channel.
// Optional macro CLKMOD_SYNC_CLR_EN adds a sync_clr input that realigns
// every channel (counter, tick, out, square state) on the next edge.
module clock_modulator_bank
  import clkmod_pkg::*;
#(
  parameter  int CLK_HZ = 50_000_000,
  parameter  int NUM_CH = 2,
  parameter  int DIV_W  = DEFAULT_DIV_W,
  localparam int LCH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              load,
  input  logic [LCH_W-1:0]  load_ch,
  input  logic [DIV_W-1:0]  load_div,
`ifdef CLKMOD_SYNC_CLR_EN
  input  logic              sync_clr,
`endif
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(HALF_SEC_DIV(CLK_HZ));

  logic              sync_clr_w;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] load_hit;

`ifdef CLKMOD_SYNC_CLR_EN
  assign sync_clr_w = sync_clr;
`else
  assign sync_clr_w = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Indices beyond NUM_CH-1 match no channel, so such loads are dropped
    localparam logic [LCH_W-1:0] IDX = LCH_W'(i);

    assign active[i]   = en & ch_en[i];
    assign load_hit[i] = load && (load_ch == IDX);

    clkmod_channel #(
      .DIV_W  (DIV_W),
      .RST_DIV(RST_DIV)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .active_i  (active[i]),
      .mode_i    (mode[i]),
      .load_i    (load_hit[i]),
      .load_div_i(load_div),
      .sync_clr_i(sync_clr_w),
      .out_o     (out[i]),
      .tick_o    (tick[i])
    );
  end

endmodule

// File: tb/tb_clock_modulator_bank.sv
// Bench for clock_modulator_bank with CLK_HZ=8, NUM_CH=2, DIV_W=8
// (reset half-period = 4). Table vectors feed a scoreboard queue;
// async reset and the optional sync_clr path have dedicated sequences.
module tb_clock_modulator_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] ch_en = 2'b00;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [0:0] load_ch = 1'b0;
  logic [7:0] load_div = 8'd0;
`ifdef CLKMOD_SYNC_CLR_EN
  logic       sync_clr = 1'b0;
`endif
  logic [1:0] out;
  logic [1:0] tick;

  clock_modulator_bank #(
    .CLK_HZ(8),
    .NUM_CH(2),
    .DIV_W (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .ch_en   (ch_en),
    .mode    (mode),
    .load    (load),
    .load_ch (load_ch),
    .load_div(load_div),
`ifdef CLKMOD_SYNC_CLR_EN
    .sync_clr(sync_clr),
`endif
    .out     (out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] ch_en;
    logic [1:0] mode;
    logic       ld;
    logic       lch;
    logic [7:0] ldiv;
    logic       sclr;
    logic [1:0] eout;
    logic [1:0] etick;
  } vec_t;

  typedef struct {
    logic [1:0] eout;
    logic [1:0] etick;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   vec_no  = 0;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic add(input logic e, input logic [1:0] ce, input logic [1:0] m,
                     input logic l, input logic lc, input logic [7:0] ld,
                     input logic s, input logic [1:0] eo, input logic [1:0] et);
    vec_t v;
    v.en = e; v.ch_en = ce; v.mode = m; v.ld = l; v.lch = lc; v.ldiv = ld;
    v.sclr = s; v.eout = eo; v.etick = et;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    en = v.en; ch_en = v.ch_en; mode = v.mode;
    load = v.ld; load_ch = v.lch; load_div = v.ldiv;
`ifdef CLKMOD_SYNC_CLR_EN
    sync_clr = v.sclr;
`endif
    e.eout = v.eout; e.etick = v.etick; e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard empty at vec%0d: got 0 entries expected 1", idx);
    end else begin
      e = sb.pop_front();
      check($sformatf("vec%0d out", e.idx), out, e.eout);
      check($sformatf("vec%0d tick", e.idx), tick, e.etick);
    end
  endtask

  task automatic run_table();
    for (int k = 0; k < vecs.size(); k++) begin
      vec_no++;
      apply(vecs[k], vec_no);
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // Reset with clock running; channels disabled through release
    #2 rst_n = 1'b0;
    ch_en = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("reset out", out, 2'b00);
    check("reset tick", tick, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-release idle out", out, 2'b00);

    //   en  ch_en  mode   ld  lch ldiv sclr out    tick
    // Both channels square at reset divider 4
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b11);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11);
    // ch1 loaded with 3 and switched to pulse mode
    add(1, 2'b11, 2'b10, 1, 1, 3, 0, 2'b00, 2'b00);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b11, 2'b11);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b01, 2'b00);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b01, 2'b00);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b11, 2'b10);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b00, 2'b01);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b10, 2'b10);
    // Load ch0 exactly in its wrap cycle: no tick, no toggle
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b11, 2'b10, 1, 0, 4, 0, 2'b00, 2'b00);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b10, 2'b10);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b11, 2'b11);
    // Global enable low for 5 cycles mid-count
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b01, 2'b00);
    for (int k = 0; k < 5; k++)
      add(0, 2'b11, 2'b10, 0, 0, 0, 0, 2'b01, 2'b00);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b01, 2'b00);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b11, 2'b10);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b00, 2'b01);
    // ch1 disabled for 2 cycles: its count is held
    add(1, 2'b01, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b01, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b11, 2'b11);
    // div = 0 on ch0: toggle and tick every cycle
    add(1, 2'b11, 2'b10, 1, 0, 0, 0, 2'b01, 2'b00);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b00, 2'b01);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b11, 2'b11);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b00, 2'b01);
    add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b01, 2'b01);
    // ch1 back to square: retained toggle state advances at its wrap
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 2'b11);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b01);
    run_table();

    // Asynchronous reset mid-count, then restart from 0 with div back to 4
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset out", out, 2'b00);
    check("async reset tick", tick, 2'b00);
    @(negedge clk);
    en = 1'b1; ch_en = 2'b11; mode = 2'b00; load = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("restart edge%0d tick", k), tick, (k == 4) ? 2'b11 : 2'b00);
      check($sformatf("restart edge%0d out", k), out, (k == 4) ? 2'b11 : 2'b00);
    end

`ifdef CLKMOD_SYNC_CLR_EN
    // Put channels at different phases, then realign with sync_clr
    add(1, 2'b11, 2'b00, 1, 1, 2, 0, 2'b11, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 2'b10);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 2'b11);
    run_table();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
